// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control unit.
// Moore-style FSM sequencing fetch/decode/execute/writeback. Control outputs
// are combinational from the current state, opcode and funct. The one Mealy
// term is the branch pc_write, which follows the ALU zero flag of the
// current cycle. A 32-bit counter tracks completed instructions.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_write,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        ext_op,
  output logic [1:0]  reg_dst,
  output logic        wd_sel,
  output logic [1:0]  alu_srca,
  output logic [1:0]  alu_srcb,
  output logic [3:0]  alu_op,
  output logic [1:0]  npc_sel,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXEC_I = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  state_t cur, nxt;
  logic   pc_write_c, ir_write_c;
  logic   retire_now;

  assign state = cur;

  // Every state that completes an instruction always returns to FETCH, so
  // being in one of them means the coming edge retires an instruction.
  assign retire_now = (cur == S_MEMWB) || (cur == S_MEMWR) || (cur == S_RWB) ||
                      (cur == S_BRANCH) || (cur == S_JUMP) || (cur == S_IWB);

  // PC and IR strobes are held off while in reset so nothing is latched
  // even though the FETCH decode is visible on the other outputs.
  assign pc_write = pc_write_c & ~rst;
  assign ir_write = ir_write_c & ~rst;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             retired <= 32'd0;
    else if (retire_now) retired <= retired + 32'd1;
  end

  // Next-state and control-output decode.
  always_comb begin
    nxt        = S_FETCH;
    pc_write_c = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write_c = 1'b0;
    reg_write  = 1'b0;
    ext_op     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 1'b0;
    alu_srca   = 2'd0;
    alu_srcb   = 2'd0;
    alu_op     = ALU_ADD;
    npc_sel    = 2'd0;
    case (cur)
      S_FETCH: begin
        ir_write_c = 1'b1;
        alu_srcb   = 2'd1;
        pc_write_c = 1'b1;
        nxt        = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively while the opcode is decoded.
        alu_srcb = 2'd3;
        ext_op   = 1'b1;
        case (op)
          OP_LW, OP_SW:              nxt = S_MEMADR;
          OP_RTYPE:                  nxt = S_EXEC_R;
          OP_BEQ:                    nxt = S_BRANCH;
          OP_J:                      nxt = S_JUMP;
          OP_ADDIU, OP_ORI, OP_LUI:  nxt = S_EXEC_I;
          default:                   nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_srca = 2'd1;
        alu_srcb = 2'd2;
        ext_op   = 1'b1;
        if (op == OP_LW)      nxt = S_MEMRD;
        else if (op == OP_SW) nxt = S_MEMWR;
        else                  nxt = S_FETCH;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        wd_sel    = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_srca = 2'd1;
        nxt      = S_RWB;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL: begin
            alu_op   = ALU_SLL;
            alu_srca = 2'd2;
          end
          FN_SRL: begin
            alu_op   = ALU_SRL;
            alu_srca = 2'd2;
          end
          // Unsupported funct: drop the instruction without a writeback.
          default: nxt = S_FETCH;
        endcase
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
      end
      S_BRANCH: begin
        alu_srca   = 2'd1;
        alu_op     = ALU_SUB;
        npc_sel    = 2'd1;
        pc_write_c = zero;
      end
      S_JUMP: begin
        npc_sel    = 2'd2;
        pc_write_c = 1'b1;
      end
      S_EXEC_I: begin
        alu_srca = 2'd1;
        alu_srcb = 2'd2;
        nxt      = S_IWB;
        case (op)
          OP_ORI:  alu_op = ALU_OR;
          OP_LUI:  alu_op = ALU_LUI;
          default: begin
            alu_op = ALU_ADD;
            ext_op = 1'b1;
          end
        endcase
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. A reference model derives,
// for each instruction, the expected state path, strobes, ALU settings and
// retired count from the instruction-set rules; directed scenarios are
// followed by a randomized instruction stream.
module tb_mc_ctrl;

  logic        clk, rst;
  logic [5:0]  op, funct;
  logic        zero;
  logic        pc_write, iord, mem_write, ir_write, reg_write, ext_op;
  logic [1:0]  reg_dst;
  logic        wd_sel;
  logic [1:0]  alu_srca, alu_srcb;
  logic [3:0]  alu_op;
  logic [1:0]  npc_sel;
  logic [3:0]  state;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_retired = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_write(pc_write), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .ext_op(ext_op),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_srca(alu_srca),
    .alu_srcb(alu_srcb), .alu_op(alu_op), .npc_sel(npc_sel),
    .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU op an R-type funct selects; known=0 for unsupported functs.
  function automatic void r_alu(input logic [5:0] f, output int aop, output bit known);
    known = 1'b1;
    case (f)
      6'h21: aop = 0;
      6'h23: aop = 1;
      6'h24: aop = 2;
      6'h25: aop = 3;
      6'h2A: aop = 4;
      6'h00: aop = 5;
      6'h02: aop = 6;
      default: begin aop = 0; known = 1'b0; end
    endcase
  endfunction

  // Expected state path of one instruction and whether it retires.
  function automatic void ref_path(input logic [5:0] o, input logic [5:0] f,
                                   output int seq[6], output int len, output bit ret);
    int aop; bit known;
    seq = '{0, 1, 0, 0, 0, 0};
    len = 2; ret = 1'b0;
    case (o)
      6'h23: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; len = 5; ret = 1; end
      6'h2B: begin seq[2] = 2; seq[3] = 5; len = 4; ret = 1; end
      6'h00: begin
        r_alu(f, aop, known);
        seq[2] = 6; len = 3;
        if (known) begin seq[3] = 7; len = 4; ret = 1; end
      end
      6'h04: begin seq[2] = 8; len = 3; ret = 1; end
      6'h02: begin seq[2] = 9; len = 3; ret = 1; end
      6'h09, 6'h0D, 6'h0F: begin seq[2] = 10; seq[3] = 11; len = 4; ret = 1; end
      default: ;
    endcase
  endfunction

  // Walks one instruction from FETCH, checking every cycle at mid-period.
  task automatic drive_instr(input logic [5:0] o, input logic [5:0] f, input string name);
    int seq[6]; int len; bit ret; int aop; bit known;
    logic e_pw, e_mw, e_iw, e_rw;
    ref_path(o, f, seq, len, ret);
    r_alu(f, aop, known);
    op = o; funct = f;
    for (int i = 0; i < len; i++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      e_pw = (seq[i] == 0) || (seq[i] == 9) || (seq[i] == 8 && zero);
      e_mw = (seq[i] == 5);
      e_iw = (seq[i] == 0);
      e_rw = (seq[i] == 4) || (seq[i] == 7) || (seq[i] == 11);
      n_checks++;
      if (state !== 4'(seq[i])) begin
        n_errors++;
        $display("FAIL %s state step %0d: got %0d expected %0d", name, i, state, seq[i]);
      end
      n_checks++;
      if ({pc_write, mem_write, ir_write, reg_write} !== {e_pw, e_mw, e_iw, e_rw}) begin
        n_errors++;
        $display("FAIL %s strobes step %0d: got %b expected %b", name, i,
                 {pc_write, mem_write, ir_write, reg_write}, {e_pw, e_mw, e_iw, e_rw});
      end
      case (seq[i])
        0: begin
          n_checks++;
          if ({iord, alu_srca, alu_srcb, alu_op, npc_sel} !== {1'b0, 2'd0, 2'd1, 4'd0, 2'd0}) begin
            n_errors++;
            $display("FAIL %s fetch ctl: got %b", name, {iord, alu_srca, alu_srcb, alu_op, npc_sel});
          end
        end
        1: begin
          n_checks++;
          if ({alu_srca, alu_srcb, alu_op, ext_op} !== {2'd0, 2'd3, 4'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL %s decode ctl: got %b", name, {alu_srca, alu_srcb, alu_op, ext_op});
          end
        end
        3, 5: begin
          n_checks++;
          if (iord !== 1'b1) begin
            n_errors++;
            $display("FAIL %s iord: got %b expected 1", name, iord);
          end
        end
        4: begin
          n_checks++;
          if ({wd_sel, reg_dst} !== {1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL %s memwb sel: got %b expected 100", name, {wd_sel, reg_dst});
          end
        end
        6: begin
          n_checks++;
          if ({alu_op, alu_srca, alu_srcb} !== {4'(aop), (aop == 5 || aop == 6) ? 2'd2 : 2'd1, 2'd0}) begin
            n_errors++;
            $display("FAIL %s exec_r: got op %0d srca %0d srcb %0d expected op %0d", name,
                     alu_op, alu_srca, alu_srcb, aop);
          end
        end
        7: begin
          n_checks++;
          if ({wd_sel, reg_dst} !== {1'b0, 2'd1}) begin
            n_errors++;
            $display("FAIL %s rwb sel: got %b expected 001", name, {wd_sel, reg_dst});
          end
        end
        8: begin
          n_checks++;
          if ({alu_op, npc_sel, alu_srca, alu_srcb} !== {4'd1, 2'd1, 2'd1, 2'd0}) begin
            n_errors++;
            $display("FAIL %s branch ctl: got %b", name, {alu_op, npc_sel, alu_srca, alu_srcb});
          end
        end
        9: begin
          n_checks++;
          if (npc_sel !== 2'd2) begin
            n_errors++;
            $display("FAIL %s jump npc_sel: got %0d expected 2", name, npc_sel);
          end
        end
        10: begin
          n_checks++;
          if ({alu_op, ext_op} !== {(o == 6'h0D) ? 4'd3 : (o == 6'h0F) ? 4'd7 : 4'd0, o == 6'h09}) begin
            n_errors++;
            $display("FAIL %s exec_i: got op %0d ext %b", name, alu_op, ext_op);
          end
        end
        default: ;
      endcase
      @(posedge clk); @(negedge clk);
    end
    if (ret) exp_retired = exp_retired + 32'd1;
    #1;
    n_checks++;
    if (state !== 4'd0 || retired !== exp_retired) begin
      n_errors++;
      $display("FAIL %s end: state %0d retired %0d expected state 0 retired %0d",
               name, state, retired, exp_retired);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_retired = 0;
    // Advance an addu into RWB, then reset there.
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 4'd7) begin
      n_errors++;
      $display("FAIL reset_setup: got state %0d expected 7", state);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0 || retired !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_async: state %0d retired %0d expected 0 0", state, retired);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({pc_write, ir_write, reg_write, mem_write, state} !== 8'h00 || alu_srcb !== 2'd1) begin
        n_errors++;
        $display("FAIL reset_hold: pw %b iw %b rw %b mw %b state %0d srcb %0d",
                 pc_write, ir_write, reg_write, mem_write, state, alu_srcb);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_errors++;
      $display("FAIL reset_release: got state %0d expected 1", state);
    end
    // Realign to FETCH at a negedge: retire nothing by running a bad op.
    op = 6'h3F;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_beq();
    drive_instr(6'h04, 6'h00, "beq_rand");
    // Force zero explicitly for both polarities in BRANCH.
    for (int z = 1; z >= 0; z--) begin
      op = 6'h04;
      @(posedge clk); @(posedge clk); @(negedge clk);
      zero = 1'(z); #1;
      n_checks++;
      if (state !== 4'd8 || pc_write !== 1'(z) || npc_sel !== 2'd1) begin
        n_errors++;
        $display("FAIL beq_zero%0d: state %0d pc_write %b npc_sel %0d", z, state, pc_write, npc_sel);
      end
      @(posedge clk); @(negedge clk);
      exp_retired = exp_retired + 32'd1;
      n_checks++;
      if (retired !== exp_retired) begin
        n_errors++;
        $display("FAIL beq_retire%0d: got %0d expected %0d", z, retired, exp_retired);
      end
    end
  endtask

  task automatic test_sw_reset();
    op = 6'h2B; funct = 6'h00;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_checks++;
    if (state !== 4'd2 || mem_write !== 1'b0) begin
      n_errors++;
      $display("FAIL sw_setup: state %0d mem_write %b expected 2 0", state, mem_write);
    end
    rst = 1'b1; #1;
    exp_retired = 0;
    n_checks++;
    if (state !== 4'd0 || retired !== 32'd0 || mem_write !== 1'b0) begin
      n_errors++;
      $display("FAIL sw_reset: state %0d retired %0d mem_write %b", state, retired, mem_write);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (mem_write !== 1'b0 || state !== 4'd0) begin
        n_errors++;
        $display("FAIL sw_hold: state %0d mem_write %b", state, mem_write);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops[9];
    logic [5:0] fns[8];
    logic [5:0] o, f;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h09, 6'h0D, 6'h0F, 6'h02, 6'h00};
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h00};
    for (int n = 0; n < 60; n++) begin
      o = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      f = ($urandom_range(0, 7) == 7) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      drive_instr(o, f, "random");
    end
  endtask

  initial begin
    test_reset();
    drive_instr(6'h23, 6'h00, "lw");
    drive_instr(6'h00, 6'h00, "sll");
    drive_instr(6'h00, 6'h02, "srl");
    drive_instr(6'h00, 6'h3F, "r_bad_funct");
    test_beq();
    drive_instr(6'h02, 6'h00, "j");
    drive_instr(6'h0F, 6'h00, "lui");
    drive_instr(6'h0D, 6'h00, "ori");
    drive_instr(6'h09, 6'h00, "addiu");
    drive_instr(6'h3F, 6'h00, "bad_op");
    drive_instr(6'h2B, 6'h00, "sw");
    test_sw_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
